// File: rtl/store_data_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : Falco_pkg
// Description : Shared constants and types for the store data buffer:
//               entry count and index width, data/address widths, the
//               per-entry storage record and the drain state encoding.
// Revision    : 1.0 - initial release
// ============================================================================

package Falco_pkg;

    localparam int SDB_NUM   = 16;  // entry count, fixed by the 4-level picker
    localparam int SDB_WIDTH = 4;   // log2(SDB_NUM)
    localparam int XLEN      = 32;  // data width
    localparam int AW        = 30;  // word-address width (byte addr [31:2])
    localparam int BE_W      = XLEN / 8;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
    } sdb_entry_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } sdb_state_e;

endpackage

`default_nettype wire

// File: rtl/store_data_buffer_combine.sv
`default_nettype none
// ============================================================================
// Module      : combine_data_unit
// Description : Picks the most recently allocated entry among those flagged
//               in a match vector. Entries are allocated in circular order,
//               so the newest one sits just below the allocation pointer.
// Ports       : match     - per-entry match flags
//               head      - allocation pointer (next slot to be written)
//               hit       - at least one entry matched
//               hit_index - index of the newest matching entry
// Revision    : 1.0 - initial release
// ============================================================================

module combine_data_unit
    import Falco_pkg::*;
(
    input  logic [SDB_NUM-1:0]   match,
    input  logic [SDB_WIDTH-1:0] head,
    output logic                 hit,
    output logic [SDB_WIDTH-1:0] hit_index
);

    // Match vector rotated so that position SDB_NUM-1 is the newest slot
    // (head-1) and position 0 is the oldest possible slot (head).
    logic [SDB_NUM-1:0]   rot;
    logic [SDB_WIDTH-1:0] src;
    logic                 node_v [SDB_NUM];
    logic [SDB_WIDTH-1:0] node_i [SDB_NUM];

    always_comb begin
        rot = '0;
        src = '0;
        for (int j = 0; j < SDB_NUM; j++) begin
            src    = head + SDB_WIDTH'(j);
            rot[j] = match[src];
        end

        for (int j = 0; j < SDB_NUM; j++) begin
            node_v[j] = rot[j];
            node_i[j] = SDB_WIDTH'(j);
        end

        // Binary tree, higher rotated position wins. Nodes are compacted in
        // place: node n of a level only reads nodes 2n/2n+1 of the previous
        // level, which are never already overwritten in the same level.
        for (int lvl = 0; lvl < SDB_WIDTH; lvl++) begin
            for (int n = 0; n < (SDB_NUM >> (lvl + 1)); n++) begin
                node_i[n] = node_v[2*n+1] ? node_i[2*n+1] : node_i[2*n];
                node_v[n] = node_v[2*n+1] | node_v[2*n];
            end
        end

        hit       = node_v[0];
        hit_index = head + node_i[0];
    end

endmodule

`default_nettype wire

// File: rtl/store_data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_data_buffer
// Description : Circular buffer of retired stores waiting for the D-side
//               memory write. Pushes merge over the newest older entry with
//               the same word address; entries drain in order, one per
//               memory handshake, with a bubble cycle between writes.
//               Optional store-to-load forwarding from the newest match.
// Config      : SDB_LOAD_FWD_EN - when defined, the load forwarding picker
//               and ld_fwd_* logic are built; otherwise ld_fwd_* are 0.
// Ports       : clk_i, rst_ni (sync, active-low)
//               push_*        - store commit interface (valid/ready)
//               ld_*          - load probe and forwarding result
//               mem_*         - memory write request / ack
//               empty_o, count_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================

module store_data_buffer
    import Falco_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 push_valid_i,
    output logic                 push_ready_o,
    input  logic [AW-1:0]        push_addr_i,
    input  logic [XLEN-1:0]      push_data_i,
    input  logic [BE_W-1:0]      push_be_i,

    input  logic [AW-1:0]        ld_addr_i,
    input  logic [BE_W-1:0]      ld_be_i,
    output logic                 ld_fwd_hit_o,
    output logic                 ld_fwd_full_o,
    output logic [XLEN-1:0]      ld_fwd_data_o,

    output logic                 mem_req_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [XLEN-1:0]      mem_data_o,
    output logic [BE_W-1:0]      mem_be_o,
    input  logic                 mem_ack_i,

    output logic                 empty_o,
    output logic [SDB_WIDTH:0]   count_o
);

    sdb_entry_t           entries [SDB_NUM];
    logic [SDB_WIDTH-1:0] push_head;
    logic [SDB_WIDTH-1:0] pop_head;
    logic [SDB_WIDTH:0]   count;
    logic [SDB_WIDTH:0]   count_next;
    sdb_state_e           state;
    sdb_state_e           state_next;

    logic [AW-1:0]        req_addr;
    logic [XLEN-1:0]      req_data;
    logic [BE_W-1:0]      req_be;

    logic                 push_fire;
    logic                 pop_fire;

    // ------------------------------------------------------------------
    // Handshakes. Ready comes from the registered count only, so a pop in
    // the same cycle never frees a slot for that cycle's push.
    // ------------------------------------------------------------------
    assign push_ready_o = (count != (SDB_WIDTH+1)'(SDB_NUM));
    assign push_fire    = push_valid_i & push_ready_o;
    assign pop_fire     = (state == S_REQ) & mem_ack_i;

    // ------------------------------------------------------------------
    // Push-side merge
    // ------------------------------------------------------------------
    logic [SDB_NUM-1:0]   push_match;
    logic                 push_hit;
    logic [SDB_WIDTH-1:0] push_hit_index;
    sdb_entry_t           merge_src;
    sdb_entry_t           new_entry;

    always_comb begin
        for (int i = 0; i < SDB_NUM; i++) begin
            push_match[i] = entries[i].valid && (entries[i].addr == push_addr_i);
        end
    end

    combine_data_unit u_push_pick (
        .match     (push_match),
        .head      (push_head),
        .hit       (push_hit),
        .hit_index (push_hit_index)
    );

    // Reads storage before this edge's pop clears a valid bit, so merging
    // over an entry that is being acked in the same cycle is safe.
    always_comb begin
        merge_src       = entries[push_hit_index];
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.addr  = push_addr_i;
        for (int k = 0; k < BE_W; k++) begin
            if (push_be_i[k]) begin
                new_entry.data[8*k +: 8] = push_data_i[8*k +: 8];
            end else if (push_hit) begin
                new_entry.data[8*k +: 8] = merge_src.data[8*k +: 8];
            end else begin
                new_entry.data[8*k +: 8] = 8'h00;
            end
        end
        new_entry.be = push_be_i | (push_hit ? merge_src.be : '0);
    end

    // ------------------------------------------------------------------
    // Storage. A push never targets pop_head while that entry is live
    // (that would need a full buffer), so the two writes cannot collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SDB_NUM; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (pop_fire) begin
                entries[pop_head].valid <= 1'b0;
            end
            if (push_fire) begin
                entries[push_head] <= new_entry;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        count_next = count;
        case ({push_fire, pop_fire})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            push_head <= '0;
            pop_head  <= '0;
            count     <= '0;
        end else begin
            if (push_fire) begin
                push_head <= push_head + 1'b1;
            end
            if (pop_fire) begin
                pop_head <= pop_head + 1'b1;
            end
            count <= count_next;
        end
    end

    assign empty_o = (count == '0);
    assign count_o = count;

    // ------------------------------------------------------------------
    // Drain FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (count != '0) state_next = S_REQ;
            S_REQ:   if (mem_ack_i)   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = (state == S_REQ);
    end

    // The head entry is captured while idle and held for the whole request;
    // the entry itself cannot change while live, so the capture is exact.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_addr <= '0;
            req_data <= '0;
            req_be   <= '0;
        end else if (state == S_IDLE) begin
            req_addr <= entries[pop_head].addr;
            req_data <= entries[pop_head].data;
            req_be   <= entries[pop_head].be;
        end
    end

    assign mem_addr_o = req_addr;
    assign mem_data_o = req_data;
    assign mem_be_o   = req_be;

    // ------------------------------------------------------------------
    // Store-to-load forwarding
    // ------------------------------------------------------------------
`ifdef SDB_LOAD_FWD_EN
    logic [SDB_NUM-1:0]   ld_match;
    logic                 ld_hit;
    logic [SDB_WIDTH-1:0] ld_hit_index;
    sdb_entry_t           ld_src;

    always_comb begin
        for (int i = 0; i < SDB_NUM; i++) begin
            ld_match[i] = entries[i].valid && (entries[i].addr == ld_addr_i);
        end
    end

    combine_data_unit u_ld_pick (
        .match     (ld_match),
        .head      (push_head),
        .hit       (ld_hit),
        .hit_index (ld_hit_index)
    );

    always_comb begin
        ld_src        = entries[ld_hit_index];
        ld_fwd_hit_o  = ld_hit;
        ld_fwd_data_o = ld_hit ? ld_src.data : '0;
        ld_fwd_full_o = ld_hit && ((ld_src.be & ld_be_i) == ld_be_i);
    end
`else
    logic unused_ld;
    assign unused_ld     = ^{ld_addr_i, ld_be_i};
    assign ld_fwd_hit_o  = 1'b0;
    assign ld_fwd_full_o = 1'b0;
    assign ld_fwd_data_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_data_buffer
// Description : Directed self-checking bench for store_data_buffer. Expected
//               memory writes are modelled (including byte merging) and
//               queued when a push is accepted, then compared in order as
//               the buffer drains.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_store_data_buffer;
    import Falco_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 push_valid;
    logic                 push_ready;
    logic [AW-1:0]        push_addr;
    logic [XLEN-1:0]      push_data;
    logic [BE_W-1:0]      push_be;
    logic [AW-1:0]        ld_addr;
    logic [BE_W-1:0]      ld_be;
    logic                 ld_fwd_hit;
    logic                 ld_fwd_full;
    logic [XLEN-1:0]      ld_fwd_data;
    logic                 mem_req;
    logic [AW-1:0]        mem_addr;
    logic [XLEN-1:0]      mem_data;
    logic [BE_W-1:0]      mem_be;
    logic                 mem_ack;
    logic                 empty;
    logic [SDB_WIDTH:0]   count;

    store_data_buffer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .push_valid_i  (push_valid),
        .push_ready_o  (push_ready),
        .push_addr_i   (push_addr),
        .push_data_i   (push_data),
        .push_be_i     (push_be),
        .ld_addr_i     (ld_addr),
        .ld_be_i       (ld_be),
        .ld_fwd_hit_o  (ld_fwd_hit),
        .ld_fwd_full_o (ld_fwd_full),
        .ld_fwd_data_o (ld_fwd_data),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_data),
        .mem_be_o      (mem_be),
        .mem_ack_i     (mem_ack),
        .empty_o       (empty),
        .count_o       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference merge: newest outstanding write to the same word supplies
    // every byte not enabled by the new store.
    task automatic model_push(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                              input logic [BE_W-1:0] be);
        wr_t e;
        int  hit_idx;
        hit_idx = -1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].addr == a) begin
                hit_idx = i;
                break;
            end
        end
        e.addr = a;
        e.be   = be;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k])             e.data[8*k +: 8] = d[8*k +: 8];
            else if (hit_idx >= 0) e.data[8*k +: 8] = sb[hit_idx].data[8*k +: 8];
            else                   e.data[8*k +: 8] = 8'h00;
        end
        if (hit_idx >= 0) e.be = be | sb[hit_idx].be;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic do_push(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                           input logic [BE_W-1:0] be, output logic accepted);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        push_be    = be;
        accepted   = push_ready;
        if (accepted) model_push(a, d, be);
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    // Waits (bounded) for a request, compares it with the oldest expected
    // write and acknowledges it for one cycle.
    task automatic drain_one(input string tag);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 64'(mem_req), 64'(sb.size() != 0));
        if (mem_req && sb.size() != 0) begin
            check({tag, "_addr"}, 64'(mem_addr), 64'(sb[0].addr));
            check({tag, "_data"}, 64'(mem_data), 64'(sb[0].data));
            check({tag, "_be"},   64'(mem_be),   64'(sb[0].be));
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            void'(sb.pop_front());
        end
    endtask

    logic acc;

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_addr  = '0;
        push_data  = '0;
        push_be    = '0;
        ld_addr    = '0;
        ld_be      = '0;
        mem_ack    = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_req",   64'(mem_req), 64'd0);
        check("rst_ready", 64'(push_ready), 64'd1);
        check("rst_fwd_hit", 64'(ld_fwd_hit), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // In-order drain
        do_push(30'h10, 32'h11111111, 4'hF, acc);
        do_push(30'h20, 32'h22222222, 4'hF, acc);
        do_push(30'h30, 32'h33333333, 4'hF, acc);
        check("order_count3", 64'(count), 64'd3);
        drain_one("order_a");
        drain_one("order_b");
        drain_one("order_c");
        check("order_count0", 64'(count), 64'd0);
        check("order_empty",  64'(empty), 64'd1);

        // Merge over an older entry of the same word
        do_push(30'h40, 32'h11223344, 4'hF, acc);
        do_push(30'h40, 32'h000000AA, 4'h1, acc);
        check("merge_count", 64'(count), 64'd2);
        drain_one("merge_first");
        drain_one("merge_second");

        // Fill, overflow attempt, wrap-around
        for (int i = 0; i < SDB_NUM; i++) begin
            do_push(AW'(30'h100 + i), 32'hA0000000 | 32'(i), 4'hF, acc);
        end
        check("full_ready", 64'(push_ready), 64'd0);
        check("full_count", 64'(count), 64'd16);
        do_push(30'h1FF, 32'hDEADDEAD, 4'hF, acc);
        check("full_drop",  64'(acc), 64'd0);
        check("full_count_after_drop", 64'(count), 64'd16);
        drain_one("full_pop0");
        check("full_pop_count", 64'(count), 64'd15);
        check("full_pop_ready", 64'(push_ready), 64'd1);
        do_push(30'h200, 32'h0BADF00D, 4'hF, acc);
        check("wrap_accept", 64'(acc), 64'd1);
        check("wrap_count",  64'(count), 64'd16);
        for (int i = 0; i < SDB_NUM; i++) begin
            drain_one($sformatf("wrap_drain%0d", i));
        end
        check("wrap_empty", 64'(empty), 64'd1);

        // Load forwarding
        do_push(30'h50, 32'h0000BEEF, 4'h3, acc);
        ld_addr = 30'h50;
        ld_be   = 4'h3;
        #1;
`ifdef SDB_LOAD_FWD_EN
        check("fwd_hit",  64'(ld_fwd_hit),  64'd1);
        check("fwd_full", 64'(ld_fwd_full), 64'd1);
        check("fwd_data", 64'(ld_fwd_data), 64'h0000BEEF);
`else
        check("fwd_hit",  64'(ld_fwd_hit),  64'd0);
        check("fwd_full", 64'(ld_fwd_full), 64'd0);
        check("fwd_data", 64'(ld_fwd_data), 64'd0);
`endif
        ld_be = 4'hF;
        #1;
`ifdef SDB_LOAD_FWD_EN
        check("fwd_partial_hit",  64'(ld_fwd_hit),  64'd1);
`else
        check("fwd_partial_hit",  64'(ld_fwd_hit),  64'd0);
`endif
        check("fwd_partial_full", 64'(ld_fwd_full), 64'd0);
        ld_addr = 30'h54;
        #1;
        check("fwd_miss_hit",  64'(ld_fwd_hit),  64'd0);
        check("fwd_miss_data", 64'(ld_fwd_data), 64'd0);
        ld_addr = '0;
        ld_be   = '0;
        @(negedge clk);
        drain_one("fwd_drain");

        // Reset while a request is outstanding, with ack asserted
        do_push(30'h60, 32'h66666666, 4'hF, acc);
        for (int n = 0; n < 10 && !mem_req; n++) @(negedge clk);
        check("midrst_req_before", 64'(mem_req), 64'd1);
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        check("midrst_req",   64'(mem_req), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_empty", 64'(empty), 64'd1);
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        check("midrst_idle_req",   64'(mem_req), 64'd0);
        check("midrst_idle_count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_data_buffer.md
Name: store_data_buffer

Overview:
- Circular buffer of retired stores awaiting the data-memory write.
- Sits between the LSU store-commit point and the D-side memory port.
- Each push merges its bytes over the latest older entry with the same word address, using the match vector and the combine_data_unit picker.
- Entries drain strictly in order, one per memory handshake.
- Provides store-to-load forwarding from the latest matching entry.

Parameters:
- SDB_NUM, 16, entry count; fixed at 16 by the 4-level picker tree.
- SDB_WIDTH, 4, index width, log2(SDB_NUM).
- XLEN, 32, data width.
- AW, 30, word-address width (byte address bits [31:2]).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- push_valid_i  in  1  store commit request
- push_ready_o  out  1  buffer can accept a push
- push_addr_i  in  AW  store word address
- push_data_i  in  XLEN  store data, byte-lane aligned
- push_be_i  in  4  byte enables
- ld_addr_i  in  AW  load word address probe
- ld_be_i  in  4  load byte enables
- ld_fwd_hit_o  out  1  latest matching entry exists
- ld_fwd_full_o  out  1  that entry covers every byte in ld_be_i
- ld_fwd_data_o  out  XLEN  data of that entry
- mem_req_o  out  1  write request
- mem_addr_o  out  AW  write word address
- mem_data_o  out  XLEN  write data
- mem_be_o  out  4  write byte enables
- mem_ack_i  in  1  write accepted
- empty_o  out  1  no valid entries
- count_o  out  SDB_WIDTH+1  valid entry count

Behaviour:
- Storage and pointers:
  - Per-entry state: valid, addr, data, be.
  - push_head (tail) and pop_head (head) are SDB_WIDTH-bit pointers that wrap modulo SDB_NUM.
  - count is a separate register.
- Reset (rst_ni=0 at a clock edge):
  - All valid bits, both pointers and count go to 0.
  - Drain FSM goes to S_IDLE.
  - Outputs: mem_req_o=0, push_ready_o=1, empty_o=1, count_o=0, ld_fwd_*=0.
  - A reset during S_REQ abandons the request the same edge; a mem_ack_i in that cycle is ignored.
- push_ready_o = (count != SDB_NUM), from registered count.
  - A pop in the same cycle does not free a slot for that cycle's push.
- Push match:
  - match[i] = valid[i] & (addr[i] == push_addr_i).
  - Fed with push_head into the picker, which returns hit and hit_index of the most recently allocated matching entry.
- Push (push_valid_i & push_ready_o): always allocate at push_head, then push_head+1.
  - Entry byte k = push_data_i byte k if push_be_i[k], else entry[hit_index] byte k if hit, else 0.
  - be = push_be_i | (hit ? be[hit_index] : 0).
  - Older entries are never modified.
- Push and pop of the same matching entry in one cycle: the merge reads the pre-pop contents, which is legal.
- Drain FSM:
  - S_IDLE: if count != 0, go to S_REQ. mem_req_o=0.
  - S_REQ:
    - Drive mem_req_o=1; address/data/be come from the pop_head entry, registered and stable until ack.
    - On mem_ack_i: clear valid[pop_head], pop_head+1, go to S_IDLE.
  - Result is one bubble cycle between writes.
  - mem_ack_i outside S_REQ is ignored.
- Count update: count += push - pop.
  - Simultaneous push and pop leave count unchanged.
  - Full plus pop gives count SDB_NUM-1 the next cycle.
- Load forwarding (combinational):
  - Same picker scheme using ld_addr_i.
  - ld_fwd_hit_o = picker hit.
  - ld_fwd_data_o = data[hit_index], else 0.
  - ld_fwd_full_o = hit & ((be[hit_index] & ld_be_i) == ld_be_i).
  - An entry being acked this cycle is still forwardable.
- Latency: push is visible to load forwarding and merge one cycle after acceptance; minimum push-to-mem_req_o is 2 cycles.

Optional Feature:
- SDB_LOAD_FWD_EN defined: second picker instance and the ld_fwd_* logic are present, as above.
- Undefined:
  - Load picker is omitted.
  - ld_fwd_hit_o, ld_fwd_full_o and ld_fwd_data_o are tied to 0.
  - ld_* inputs are unused.
  - Push path is unchanged.

Decomposition:
- Falco_pkg holds:
  - SDB_NUM and SDB_WIDTH.
  - sdb_entry_t packed struct {valid, addr, data, be}.
  - sdb_state_e enum {S_IDLE, S_REQ}.
- Sub-module: combine_data_unit, instantiated once for the push path and once more under SDB_LOAD_FWD_EN.
- No other sub-module.

Test Plan:
- Reset: rst_ni=0 for 2 cycles → empty_o=1, count_o=0, mem_req_o=0, push_ready_o=1.
- In-order drain: push A=0x10/0x11111111, B=0x20/0x22222222, C=0x30/0x33333333, be=4'hF, mem_ack_i one cycle after each req → mem_addr_o sequence 0x10, 0x20, 0x30; count_o 3→0; empty_o=1.
- Merge: with mem_ack_i=0, push 0x40/0x11223344/be F, then 0x40/0x000000AA/be 1 → second entry data 0x112233AA, be F; drains write 0x11223344 then 0x112233AA.
- Full and wrap-around:
  - mem_ack_i=0, 16 pushes → push_ready_o=0, a 17th push is dropped, count_o=16.
  - Ack one, then push → accepted into slot 0 (wrap), count_o=16.
- Load forwarding (SDB_LOAD_FWD_EN):
  - Entry 0x50/be 4'h3/0x0000BEEF.
  - Probe 0x50 be 3 → hit=1, full=1, data 0x0000BEEF.
  - Probe be F → hit=1, full=0.
  - Probe 0x54 → hit=0.
- Reset mid-drain: assert rst_ni=0 in S_REQ with mem_ack_i=1 → next cycle mem_req_o=0, count_o=0, no pop.
